tile_config_mem_shadow: RTL and testbench
=========================================

TILE_CONFIG_MEM_SHADOW -- requirements
Module: tile_config_mem_shadow

Interface
REQ-001 SHALL have parameter MAX_FRAMES_PER_COL, default 20, frame strobes per column.
REQ-002 SHALL have parameter FRAME_BITS_PER_ROW, default 32, data bits per frame.
REQ-003 SHALL have parameter NO_CONFIG_BITS, default 640, config bits exported; legal range 1..MAX_FRAMES_PER_COL*FRAME_BITS_PER_ROW.
REQ-004 SHALL have parameter EMULATE_BITSTREAM, default all-zero, width MAX_FRAMES_PER_COL*FRAME_BITS_PER_ROW, reset image.
REQ-005 SHALL derive NUM_FRAMES = ceil(NO_CONFIG_BITS/FRAME_BITS_PER_ROW) and FIDX_W = clog2(MAX_FRAMES_PER_COL), minimum 1.
REQ-006 Ports, one clock; reset is asynchronous and active-low:
  CLK  in  1  clock
  resetn  in  1  asynchronous active-low reset
  FrameData  in  FRAME_BITS_PER_ROW  frame write data
  FrameStrobe  in  MAX_FRAMES_PER_COL  per-frame write strobe, one-hot expected
  commit_req  in  1  request copy of shadow to active
  rb_req  in  1  readback request
  rb_sel  in  1  0 = read active bank, 1 = read shadow bank
  rb_frame  in  FIDX_W  readback frame index
  ConfigBits  out  NO_CONFIG_BITS  active configuration
  ConfigBits_N  out  NO_CONFIG_BITS  bitwise inverse of ConfigBits
  commit_done  out  1  one-cycle pulse, commit applied
  rb_valid  out  1  readback data valid
  rb_data  out  FRAME_BITS_PER_ROW  readback data
  err  out  1  one-cycle pulse on any protocol error

Function
REQ-007 Config bit i SHALL map to frame i/FRAME_BITS_PER_ROW, bit i%FRAME_BITS_PER_ROW, in both banks.
REQ-008 Strobe bit f < NUM_FRAMES high on a rising CLK SHALL write FrameData into shadow frame f and set dirty[f]; active bank unchanged.
REQ-009 Strobe bits f >= NUM_FRAMES SHALL be ignored without error.
REQ-010 More than one strobe bit high in a cycle SHALL write nothing and pulse err next cycle.
REQ-011 FSM states: IDLE (dirty all clear), LOADING (any dirty set), COMMIT (copy cycle).
REQ-012 IDLE -> LOADING on first valid write; LOADING -> COMMIT when commit_req is high and dirty (including same-cycle write) is all-ones over NUM_FRAMES.
REQ-013 commit_req in LOADING with incomplete dirty, or in IDLE, SHALL pulse err and not change state.
REQ-014 In COMMIT the active bank SHALL take the whole shadow bank atomically on one edge; dirty cleared; next state IDLE; commit_done high for exactly the following cycle.
REQ-015 Strobe or commit_req during COMMIT SHALL be dropped and pulse err.
REQ-016 ConfigBits SHALL change only on the commit edge; ConfigBits_N SHALL always equal ~ConfigBits.
REQ-017 Readback latency SHALL be 1 cycle: rb_req at edge N gives rb_valid high and rb_data during cycle N+1; back-to-back requests give back-to-back data.
REQ-018 rb_frame >= NUM_FRAMES SHALL return rb_data zero, rb_valid high, and pulse err.
REQ-019 Readback of shadow frame written on the same edge SHALL return the new data; active readback on the commit edge SHALL return the pre-commit data.
REQ-020 rb_data SHALL hold zero when rb_valid is low.

Reset
REQ-021 resetn low SHALL immediately load both banks from EMULATE_BITSTREAM, clear dirty, enter IDLE, and force commit_done, rb_valid, err and rb_data to zero.
REQ-022 Reset during LOADING or COMMIT SHALL abandon the operation; no partial copy is visible.

Structure
REQ-023 FSM state enumeration and the NUM_FRAMES/FIDX_W derivation functions SHALL live in the shared package tile_cfg_pkg.
REQ-024 One sub-module, cfg_frame_bank (parametrised frame storage with per-frame write enable and full-width parallel load), SHALL be instantiated twice, shadow and active.

Verification
REQ-025 Reset with EMULATE_BITSTREAM bit 5 set -> ConfigBits[5]=1, ConfigBits_N[5]=0, rb_valid=0.
REQ-026 Write frames 0..19 with 0xA5A5_0000+f, commit_req -> ConfigBits unchanged until commit edge, commit_done one cycle, frame 3 active readback = 0xA5A50003.
REQ-027 Write frames 0..18 only, commit_req -> err pulse, ConfigBits unchanged, state LOADING.
REQ-028 FrameStrobe=0x00003 -> err pulse, shadow readback of frames 0 and 1 unchanged.
REQ-029 Write frame 19 and commit_req same cycle with 0..18 dirty -> commit accepted, commit_done two cycles later.
REQ-030 rb_frame=25 -> rb_valid=1, rb_data=0, err pulse; resetn low during COMMIT -> ConfigBits = reset image.

Source files
------------

// File: rtl/tile_cfg_pkg.sv
// Shared types and size helpers for the tile configuration shadow memory.
// Holds the controller state encoding and the frame-count derivations.
package tile_cfg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOADING = 2'd1,
      ST_COMMIT  = 2'd2
   } cfg_state_e;

   // Frames needed to hold a given number of config bits (rounded up).
   function automatic int num_frames_f(
      input int bits,
      input int fbits
   );
      return (bits + fbits - 1) / fbits;
   endfunction

   // Index width for a frame count, never narrower than one bit.
   function automatic int fidx_w_f(
      input int n
   );
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tile_config_mem_shadow_bank.sv
// Frame-organised storage bank: per-frame writes or whole-bank load.
// Reset loads the supplied image asynchronously.
module cfg_frame_bank #(
   parameter int            NF   = 20,
   parameter int            FB   = 32,
   parameter logic [NF*FB-1:0] INIT = '0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [NF-1:0]    i_we,
   input  logic [FB-1:0]    i_wdata,
   input  logic             i_load,
   input  logic [NF*FB-1:0] i_load_data,
   output logic [NF*FB-1:0] o_data
);

   logic [NF*FB-1:0] r_mem;

   // Whole-bank load wins over frame writes; otherwise update enabled frames.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mem <= INIT;
      end else if (i_load) begin
         r_mem <= i_load_data;
      end else begin
         for (int f = 0; f < NF; f++) begin
            if (i_we[f]) begin
               r_mem[f*FB +: FB] <= i_wdata;
            end
         end
      end
   end

   assign o_data = r_mem;

endmodule

// File: rtl/tile_config_mem_shadow.sv
// Double-buffered tile configuration memory with frame loading,
// atomic shadow-to-active commit and single-cycle readback.
module tile_config_mem_shadow
   import tile_cfg_pkg::*;
#(
   parameter int MAX_FRAMES_PER_COL = 20,
   parameter int FRAME_BITS_PER_ROW = 32,
   parameter int NO_CONFIG_BITS     = 640,
   parameter logic [MAX_FRAMES_PER_COL*FRAME_BITS_PER_ROW-1:0]
                 EMULATE_BITSTREAM  = '0,
   localparam int FIDX_W = fidx_w_f(MAX_FRAMES_PER_COL)
) (
   input  logic                          CLK,
   input  logic                          resetn,
   input  logic [FRAME_BITS_PER_ROW-1:0] FrameData,
   input  logic [MAX_FRAMES_PER_COL-1:0] FrameStrobe,
   input  logic                          commit_req,
   input  logic                          rb_req,
   input  logic                          rb_sel,
   input  logic [FIDX_W-1:0]             rb_frame,
   output logic [NO_CONFIG_BITS-1:0]     ConfigBits,
   output logic [NO_CONFIG_BITS-1:0]     ConfigBits_N,
   output logic                          commit_done,
   output logic                          rb_valid,
   output logic [FRAME_BITS_PER_ROW-1:0] rb_data,
   output logic                          err
);

   localparam int FB = FRAME_BITS_PER_ROW;
   localparam int NF = num_frames_f(NO_CONFIG_BITS, FB);
   localparam int BW = NF * FB;
   localparam logic [BW-1:0] INIT = EMULATE_BITSTREAM[BW-1:0];

   cfg_state_e r_state;
   cfg_state_e w_state_nx;

   logic [NF-1:0] r_dirty;
   logic [NF-1:0] w_wr_mask;
   logic [NF-1:0] w_dirty_nx;
   logic [MAX_FRAMES_PER_COL-1:0] w_strb_m1;
   logic          w_multi;
   logic          w_any_strb;
   logic          w_wr_any;
   logic          w_full;
   logic          w_fsm_err;
   logic          w_rb_oob;
   logic          w_err;
   logic          w_commit;
   logic [BW-1:0] w_shadow;
   logic [BW-1:0] w_active;
   logic [FB-1:0] w_sh_frame;
   logic [FB-1:0] w_act_frame;

   logic          r_commit_done;
   logic          r_err;
   logic          r_rb_valid;
   logic [FB-1:0] r_rb_data;

   // A strobe word with two or more bits set is rejected outright.
   assign w_strb_m1  = FrameStrobe - MAX_FRAMES_PER_COL'(1);
   assign w_multi    = |(FrameStrobe & w_strb_m1);
   assign w_any_strb = |FrameStrobe;
   assign w_commit   = (r_state == ST_COMMIT);

   // Shadow is frozen while the copy is in flight.
   assign w_wr_mask  = (!w_multi && !w_commit) ?
                       FrameStrobe[NF-1:0] : '0;
   assign w_wr_any   = |w_wr_mask;
   assign w_dirty_nx = r_dirty | w_wr_mask;
   assign w_full     = &w_dirty_nx;

   cfg_frame_bank #(
      .NF   (NF),
      .FB   (FB),
      .INIT (INIT)
   ) u_shadow (
      .i_clk       (CLK),
      .i_rst_n     (resetn),
      .i_we        (w_wr_mask),
      .i_wdata     (FrameData),
      .i_load      (1'b0),
      .i_load_data ('0),
      .o_data      (w_shadow)
   );

   cfg_frame_bank #(
      .NF   (NF),
      .FB   (FB),
      .INIT (INIT)
   ) u_active (
      .i_clk       (CLK),
      .i_rst_n     (resetn),
      .i_we        ('0),
      .i_wdata     ('0),
      .i_load      (w_commit),
      .i_load_data (w_shadow),
      .o_data      (w_active)
   );

   // Controller state register.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Next-state and protocol-error decode.
   always_comb begin
      w_state_nx = r_state;
      w_fsm_err  = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_wr_any) w_state_nx = ST_LOADING;
            if (commit_req) w_fsm_err = 1'b1;
         end
         ST_LOADING: begin
            if (commit_req) begin
               if (w_full) w_state_nx = ST_COMMIT;
               else        w_fsm_err  = 1'b1;
            end
         end
         ST_COMMIT: begin
            w_state_nx = ST_IDLE;
            if (commit_req || w_any_strb) w_fsm_err = 1'b1;
         end
         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase
   end

   // Dirty flags track frames loaded since the last commit.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         r_dirty <= '0;
      end else if (w_commit) begin
         r_dirty <= '0;
      end else begin
         r_dirty <= w_dirty_nx;
      end
   end

   // Frame select for readback; shadow forwards a same-edge write.
   always_comb begin
      w_rb_oob    = (int'(rb_frame) >= NF);
      w_sh_frame  = '0;
      w_act_frame = '0;
      for (int f = 0; f < NF; f++) begin
         if (int'(rb_frame) == f) begin
            w_act_frame = w_active[f*FB +: FB];
            w_sh_frame  = w_wr_mask[f] ? FrameData
                                       : w_shadow[f*FB +: FB];
         end
      end
   end

   assign w_err = w_multi | w_fsm_err | (rb_req & w_rb_oob);

   // Registered status pulses and readback data.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         r_commit_done <= 1'b0;
         r_err         <= 1'b0;
         r_rb_valid    <= 1'b0;
         r_rb_data     <= '0;
      end else begin
         r_commit_done <= w_commit;
         r_err         <= w_err;
         r_rb_valid    <= rb_req;
         if (rb_req && !w_rb_oob) begin
            r_rb_data <= rb_sel ? w_sh_frame : w_act_frame;
         end else begin
            r_rb_data <= '0;
         end
      end
   end

   assign ConfigBits   = w_active[NO_CONFIG_BITS-1:0];
   assign ConfigBits_N = ~w_active[NO_CONFIG_BITS-1:0];
   assign commit_done  = r_commit_done;
   assign err          = r_err;
   assign rb_valid     = r_rb_valid;
   assign rb_data      = r_rb_data;

endmodule

// File: tb/tb_tile_config_mem_shadow.sv
// Bench for tile_config_mem_shadow: directed load/commit/readback
// vectors with a queue-based readback scoreboard.
module tb_tile_config_mem_shadow;

   localparam int MF = 20;
   localparam int FB = 32;
   localparam int NB = 640;
   localparam logic [MF*FB-1:0] IMG = 640'h20;

   logic          clk;
   logic          resetn;
   logic [FB-1:0] FrameData;
   logic [MF-1:0] FrameStrobe;
   logic          commit_req;
   logic          rb_req;
   logic          rb_sel;
   logic [4:0]    rb_frame;
   logic [NB-1:0] ConfigBits;
   logic [NB-1:0] ConfigBits_N;
   logic          commit_done;
   logic          rb_valid;
   logic [FB-1:0] rb_data;
   logic          err;

   int errors = 0;
   int checks = 0;
   logic [FB-1:0] exp_q[$];
   logic [FB-1:0] e;
   logic [NB-1:0] exp_cfg;

   tile_config_mem_shadow #(
      .MAX_FRAMES_PER_COL (MF),
      .FRAME_BITS_PER_ROW (FB),
      .NO_CONFIG_BITS     (NB),
      .EMULATE_BITSTREAM  (IMG)
   ) dut (
      .CLK          (clk),
      .resetn       (resetn),
      .FrameData    (FrameData),
      .FrameStrobe  (FrameStrobe),
      .commit_req   (commit_req),
      .rb_req       (rb_req),
      .rb_sel       (rb_sel),
      .rb_frame     (rb_frame),
      .ConfigBits   (ConfigBits),
      .ConfigBits_N (ConfigBits_N),
      .commit_done  (commit_done),
      .rb_valid     (rb_valid),
      .rb_data      (rb_data),
      .err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", n, act, exp);
      end
   endtask

   task automatic chkw(input string n, input logic [NB-1:0] act,
                       input logic [NB-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", n, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      FrameData   = '0;
      FrameStrobe = '0;
      commit_req  = 1'b0;
      rb_req      = 1'b0;
      rb_sel      = 1'b0;
      rb_frame    = '0;
   endtask

   task automatic rd(input logic sel, input int fr,
                     input logic [31:0] exp);
      rb_req   = 1'b1;
      rb_sel   = sel;
      rb_frame = 5'(fr);
      exp_q.push_back(exp);
   endtask

   task automatic wr(input int fr, input logic [31:0] d);
      FrameStrobe = MF'(1) << fr;
      FrameData   = d;
   endtask

   // Readback monitor: each valid beat is matched against the queue.
   always @(negedge clk) begin
      if (rb_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rb_unexpected: got %h want none", rb_data);
         end else begin
            e = exp_q.pop_front();
            if (rb_data !== e) begin
               errors++;
               $display("FAIL rb_data: got %h want %h", rb_data, e);
            end
         end
      end
   end

   initial begin
      idle();
      resetn = 1'b1;
      exp_cfg = IMG;
      #1 resetn = 1'b0;
      #2;
      chk("rst_cfg5", 32'(ConfigBits[5]), 32'd1);
      chk("rst_cfgn5", 32'(ConfigBits_N[5]), 32'd0);
      chkw("rst_cfg", ConfigBits, IMG);
      chk("rst_rbv", 32'(rb_valid), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_done", 32'(commit_done), 32'd0);
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      cyc();

      // Reset image visible in both banks.
      rd(1'b1, 0, 32'h20);
      cyc();
      rd(1'b0, 0, 32'h20);
      cyc();
      idle();

      // Multi-hot strobe: nothing written, err pulse.
      FrameStrobe = 20'h00003;
      FrameData   = 32'hFFFF_FFFF;
      cyc();
      chk("multi_err", 32'(err), 32'd1);
      idle();
      rd(1'b1, 0, 32'h20);
      cyc();
      chk("multi_err_clr", 32'(err), 32'd0);
      rd(1'b1, 1, 32'h0);
      cyc();
      idle();

      // Partial load then commit request: rejected.
      for (int f = 0; f < 19; f++) begin
         wr(f, 32'hA5A5_0000 + 32'(f));
         cyc();
      end
      idle();
      commit_req = 1'b1;
      cyc();
      chk("part_err", 32'(err), 32'd1);
      chk("part_done", 32'(commit_done), 32'd0);
      chkw("part_cfg", ConfigBits, IMG);
      idle();
      rd(1'b1, 3, 32'hA5A5_0003);
      cyc();
      rd(1'b0, 3, 32'h0);
      cyc();
      idle();

      // Last frame and commit in the same cycle.
      wr(19, 32'hA5A5_0013);
      commit_req = 1'b1;
      cyc();
      chk("acc_err", 32'(err), 32'd0);
      chk("acc_done0", 32'(commit_done), 32'd0);
      chkw("acc_cfg_hold", ConfigBits, IMG);
      idle();
      wr(0, 32'h0);
      rd(1'b0, 3, 32'h0);
      cyc();
      for (int f = 0; f < MF; f++)
         exp_cfg[f*FB +: FB] = 32'hA5A5_0000 + 32'(f);
      chk("commit_done1", 32'(commit_done), 32'd1);
      chk("commit_strb_err", 32'(err), 32'd1);
      chkw("commit_cfg", ConfigBits, exp_cfg);
      chkw("commit_cfgn", ConfigBits_N, ~exp_cfg);
      idle();
      rd(1'b1, 0, 32'hA5A5_0000);
      cyc();
      chk("commit_done_end", 32'(commit_done), 32'd0);
      chk("post_err", 32'(err), 32'd0);
      rd(1'b0, 3, 32'hA5A5_0003);
      cyc();
      rd(1'b0, 19, 32'hA5A5_0013);
      cyc();
      idle();

      // Commit request while idle.
      commit_req = 1'b1;
      cyc();
      chk("idle_commit_err", 32'(err), 32'd1);
      idle();
      cyc();
      chkw("idle_commit_cfg", ConfigBits, exp_cfg);

      // Out-of-range readback.
      rd(1'b0, 25, 32'h0);
      cyc();
      chk("oob_err", 32'(err), 32'd1);
      idle();

      // Same-edge shadow write and readback.
      wr(2, 32'h1234_5678);
      rd(1'b1, 2, 32'h1234_5678);
      cyc();
      idle();
      rd(1'b0, 2, 32'hA5A5_0002);
      cyc();
      idle();

      // Full reload, then reset while the commit is in flight.
      for (int f = 0; f < MF; f++) begin
         wr(f, 32'hDEAD_0000 + 32'(f));
         if (f == MF - 1) commit_req = 1'b1;
         cyc();
      end
      idle();
      #2 resetn = 1'b0;
      #1;
      chkw("rstc_cfg", ConfigBits, IMG);
      chkw("rstc_cfgn", ConfigBits_N, ~IMG);
      chk("rstc_done", 32'(commit_done), 32'd0);
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      cyc();
      chkw("rstc_cfg_after", ConfigBits, IMG);
      chk("rstc_done_after", 32'(commit_done), 32'd0);
      rd(1'b1, 0, 32'h20);
      cyc();
      idle();
      cyc();
      cyc();
      chk("rb_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
